// File: rtl/sd_wb_pkg.sv
// Shared constants and types for the SD host Wishbone register front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sd_wb_pkg;

    localparam int cWishboneWidth = 32;
    localparam int cRegAddrWidth  = 3;

    // Wishbone B4 registered-feedback cycle type; every type is serviced as classic
    typedef enum logic [2:0] {
        cCtiClassic = 3'b000,
        cCtiConst   = 3'b001,
        cCtiIncr    = 3'b010,
        cCtiEnd     = 3'b111
    } cti_e;

    // Register map, selected by ADR_O[6:4]
    localparam logic [cRegAddrWidth-1:0] cRegStatus    = 3'd0;
    localparam logic [cRegAddrWidth-1:0] cRegOperation = 3'd1;
    localparam logic [cRegAddrWidth-1:0] cRegStartAddr = 3'd2;
    localparam logic [cRegAddrWidth-1:0] cRegEndAddr   = 3'd3;
    localparam logic [cRegAddrWidth-1:0] cRegReadData  = 3'd4;
    localparam logic [cRegAddrWidth-1:0] cRegWriteData = 3'd5;

    // Operation codes understood by the controller core
    localparam logic [cWishboneWidth-1:0] cOpRead  = 32'h10;
    localparam logic [cWishboneWidth-1:0] cOpWrite = 32'h01;

    // Status register bit positions
    localparam int cStatIdleBit    = 0;
    localparam int cStatRdAvailBit = 1;
    localparam int cStatWrSpaceBit = 2;

endpackage

// File: rtl/sd_wb_slave_if.sv
// Wishbone B4 bus bundle between the system master and the SD register slave.
// Latency: n/a (wires only).
// Backpressure: slave terminates each cycle with exactly one of ACK/ERR/RTY.
interface sd_wb_slave_if;
    import sd_wb_pkg::*;

    logic                      CYC_O;
    logic                      STB_O;
    logic                      WE_O;
    logic [cRegAddrWidth-1:0]  ADR_O;
    logic [cWishboneWidth-1:0] DAT_O;
    logic                      SEL_O;
    logic [2:0]                CTI_O;
    logic                      LOCK_O;
    logic [31:0]               TGA_O;
    logic [31:0]               TGC_O;
    logic                      TGD_O;

    logic                      ACK_I;
    logic                      ERR_I;
    logic                      RTY_I;
    logic [cWishboneWidth-1:0] DAT_I;

    modport master (
        output CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, CTI_O, LOCK_O, TGA_O, TGC_O, TGD_O,
        input  ACK_I, ERR_I, RTY_I, DAT_I
    );

    modport slave (
        input  CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, CTI_O, LOCK_O, TGA_O, TGC_O, TGD_O,
        output ACK_I, ERR_I, RTY_I, DAT_I
    );

endinterface

// File: rtl/sd_wb_slave.sv
// Wishbone register slave: operation/address registers, op req/ack to the core, FIFO bridge.
// Latency: termination one cycle after CYC&STB is sampled in Idle; at most one transfer per 2 cycles.
// Backpressure: RTY when the read FIFO is empty, write FIFO full, or the core is busy; ERR on bad access.
module sd_wb_slave
    import sd_wb_pkg::*;
(
    input  logic                      CLK_I,
    input  logic                      inResetAsync,
    sd_wb_slave_if.slave              wb,
    output logic                      oOpReq,
    input  logic                      iOpAck,
    input  logic                      iCtrlIdle,
    output logic [cWishboneWidth-1:0] oOperation,
    output logic [cWishboneWidth-1:0] oStartAddr,
    output logic [cWishboneWidth-1:0] oEndAddr,
    input  logic [cWishboneWidth-1:0] iRdFifoData,
    input  logic                      iRdFifoEmpty,
    output logic                      oRdFifoRdEn,
    output logic [cWishboneWidth-1:0] oWrFifoData,
    output logic                      oWrFifoWrEn,
    input  logic                      iWrFifoFull
);

    typedef enum logic {ST_IDLE, ST_RESPOND} state_e;

    state_e                    state_q, state_d;
    logic                      ack_q, ack_d, err_q, err_d, rty_q, rty_d;
    logic [cWishboneWidth-1:0] dat_q, dat_d;
    logic [cWishboneWidth-1:0] op_q, op_d, start_q, start_d, end_addr_q, end_addr_d;
    logic                      op_req_q, op_req_d;
    logic                      rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [cWishboneWidth-1:0] wr_dat_q, wr_dat_d;
    logic [cWishboneWidth-1:0] status;
    logic                      busy;

    // Lock, tags and cycle type carry no meaning for this slave
    logic unused_ok;
    assign unused_ok = ^{wb.CTI_O, wb.LOCK_O, wb.TGA_O, wb.TGC_O, wb.TGD_O};

    // Parameter registers must not move while the core holds a pending operation
    assign busy = op_req_q | ~iCtrlIdle;

    // Bus state register
    always_ff @(posedge CLK_I or negedge inResetAsync) begin
        if (!inResetAsync) state_q <= ST_IDLE;
        else               state_q <= state_d;
    end

    // Decode the sampled request: termination, read data and all side effects
    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rty_d      = 1'b0;
        dat_d      = '0;
        op_d       = op_q;
        start_d    = start_q;
        end_addr_d = end_addr_q;
        op_req_d   = op_req_q;
        rd_en_d    = 1'b0;
        wr_en_d    = 1'b0;
        wr_dat_d   = wr_dat_q;
        status                  = '0;
        status[cStatIdleBit]    = iCtrlIdle & ~op_req_q;
        status[cStatRdAvailBit] = ~iRdFifoEmpty;
        status[cStatWrSpaceBit] = ~iWrFifoFull;

        if (op_req_q && iOpAck) op_req_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wb.CYC_O && wb.STB_O) begin
                    state_d = ST_RESPOND;
                    if (wb.WE_O) begin
                        case (wb.ADR_O)
                            cRegOperation, cRegStartAddr, cRegEndAddr: begin
                                if (busy) begin
                                    rty_d = 1'b1;
                                end else begin
                                    ack_d = 1'b1;
                                    if (wb.SEL_O) begin
                                        case (wb.ADR_O)
                                            cRegOperation: begin
                                                op_d     = wb.DAT_O;
                                                op_req_d = 1'b1;
                                            end
                                            cRegStartAddr: start_d    = wb.DAT_O;
                                            default:       end_addr_d = wb.DAT_O;
                                        endcase
                                    end
                                end
                            end
                            cRegWriteData: begin
                                if (iWrFifoFull) begin
                                    rty_d = 1'b1;
                                end else begin
                                    ack_d = 1'b1;
                                    if (wb.SEL_O) begin
                                        wr_en_d  = 1'b1;
                                        wr_dat_d = wb.DAT_O;
                                    end
                                end
                            end
                            default: err_d = 1'b1;
                        endcase
                    end else begin
                        case (wb.ADR_O)
                            cRegStatus: begin
                                ack_d = 1'b1;
                                dat_d = status;
                            end
                            cRegOperation: begin
                                ack_d = 1'b1;
                                dat_d = op_q;
                            end
                            cRegStartAddr: begin
                                ack_d = 1'b1;
                                dat_d = start_q;
                            end
                            cRegEndAddr: begin
                                ack_d = 1'b1;
                                dat_d = end_addr_q;
                            end
                            cRegReadData: begin
                                if (iRdFifoEmpty) begin
                                    rty_d = 1'b1;
                                end else begin
                                    // Show-ahead head is captured now; the pop lands in Respond
                                    ack_d   = 1'b1;
                                    dat_d   = iRdFifoData;
                                    rd_en_d = 1'b1;
                                end
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Response, parameter and FIFO-strobe registers
    always_ff @(posedge CLK_I or negedge inResetAsync) begin
        if (!inResetAsync) begin
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rty_q      <= 1'b0;
            dat_q      <= '0;
            op_q       <= '0;
            start_q    <= '0;
            end_addr_q <= '0;
            op_req_q   <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_dat_q   <= '0;
        end else begin
            ack_q      <= ack_d;
            err_q      <= err_d;
            rty_q      <= rty_d;
            dat_q      <= dat_d;
            op_q       <= op_d;
            start_q    <= start_d;
            end_addr_q <= end_addr_d;
            op_req_q   <= op_req_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            wr_dat_q   <= wr_dat_d;
        end
    end

    assign wb.ACK_I    = ack_q;
    assign wb.ERR_I    = err_q;
    assign wb.RTY_I    = rty_q;
    assign wb.DAT_I    = dat_q;
    assign oOpReq      = op_req_q;
    assign oOperation  = op_q;
    assign oStartAddr  = start_q;
    assign oEndAddr    = end_addr_q;
    assign oRdFifoRdEn = rd_en_q;
    assign oWrFifoData = wr_dat_q;
    assign oWrFifoWrEn = wr_en_q;

endmodule

// File: tb/tb_sd_wb_slave.sv
// Self-checking bench for sd_wb_slave: directed scenarios, then randomized bus traffic.
// Latency: expects termination one cycle after the sampling edge.
// Backpressure: bench acts as read FIFO (queue) and write FIFO (full flag).
module tb_sd_wb_slave;
    import sd_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_ack = 1'b0;
    logic        ctrl_idle = 1'b1;
    logic        rd_empty = 1'b1;
    logic [31:0] rd_data = '0;
    logic        wr_full = 1'b0;
    logic        op_req, rd_en, wr_en;
    logic [31:0] op_reg, start_reg, end_reg, wr_data;

    int checks = 0;
    int errors = 0;

    // Environment read FIFO and reference model state
    logic [31:0] rdq[$];
    logic [31:0] m_op, m_start, m_end;
    logic        m_opreq;

    sd_wb_slave_if wb();

    sd_wb_slave dut (
        .CLK_I        (clk),
        .inResetAsync (rst_n),
        .wb           (wb),
        .oOpReq       (op_req),
        .iOpAck       (op_ack),
        .iCtrlIdle    (ctrl_idle),
        .oOperation   (op_reg),
        .oStartAddr   (start_reg),
        .oEndAddr     (end_reg),
        .iRdFifoData  (rd_data),
        .iRdFifoEmpty (rd_empty),
        .oRdFifoRdEn  (rd_en),
        .oWrFifoData  (wr_data),
        .oWrFifoWrEn  (wr_en),
        .iWrFifoFull  (wr_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic upd_rdfifo();
        rd_empty = (rdq.size() == 0);
        rd_data  = (rdq.size() == 0) ? 32'h0 : rdq[0];
    endtask

    task automatic model_reset();
        m_op = '0; m_start = '0; m_end = '0; m_opreq = 1'b0;
    endtask

    // Expected outcome of one access: term is {ack,err,rty}
    function automatic void model_expect(input logic we, input logic [2:0] adr, input logic sel,
                                         output logic [2:0] term, output logic [31:0] rdat,
                                         output logic pop, output logic push);
        logic bsy;
        bsy  = m_opreq || !ctrl_idle;
        term = 3'b100; rdat = '0; pop = 1'b0; push = 1'b0;
        if (adr > 3'd5) term = 3'b010;
        else if (we) begin
            if (adr == 3'd0 || adr == 3'd4) term = 3'b010;
            else if (adr == 3'd5) begin
                if (wr_full) term = 3'b001;
                else push = sel;
            end else if (bsy) term = 3'b001;
        end else begin
            if (adr == 3'd5) term = 3'b010;
            else if (adr == 3'd4) begin
                if (rdq.size() == 0) term = 3'b001;
                else begin rdat = rdq[0]; pop = 1'b1; end
            end else if (adr == 3'd0)
                rdat = {29'd0, !wr_full, rdq.size() != 0, ctrl_idle && !m_opreq};
            else if (adr == 3'd1) rdat = m_op;
            else if (adr == 3'd2) rdat = m_start;
            else rdat = m_end;
        end
    endfunction

    task automatic bus_txn(input string tag, input logic we, input logic [2:0] adr,
                           input logic [31:0] wdat, input logic sel);
        logic [2:0]  eterm;
        logic [31:0] erdat;
        logic        epop, epush, seen_pop;
        model_expect(we, adr, sel, eterm, erdat, epop, epush);
        @(negedge clk);
        wb.CYC_O = 1'b1; wb.STB_O = 1'b1; wb.WE_O = we; wb.ADR_O = adr;
        wb.DAT_O = wdat; wb.SEL_O = sel;
        wb.CTI_O = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b010;
        @(posedge clk); #1;
        chk({tag, ":term"}, {29'd0, wb.ACK_I, wb.ERR_I, wb.RTY_I}, {29'd0, eterm});
        chk({tag, ":dat"}, wb.DAT_I, erdat);
        chk({tag, ":pop"}, {31'd0, rd_en}, {31'd0, epop});
        chk({tag, ":push"}, {31'd0, wr_en}, {31'd0, epush});
        if (epush) chk({tag, ":pushdat"}, wr_data, wdat);
        seen_pop = rd_en;
        if (eterm == 3'b100 && we && sel) begin
            if (adr == 3'd1) begin m_op = wdat; m_opreq = 1'b1; end
            if (adr == 3'd2) m_start = wdat;
            if (adr == 3'd3) m_end = wdat;
        end
        chk({tag, ":opreq"}, {31'd0, op_req}, {31'd0, m_opreq});
        chk({tag, ":op"}, op_reg, m_op);
        chk({tag, ":start"}, start_reg, m_start);
        chk({tag, ":end"}, end_reg, m_end);
        @(negedge clk);
        wb.CYC_O = 1'b0; wb.STB_O = 1'b0;
        if (seen_pop === 1'b1 && rdq.size() != 0) begin
            void'(rdq.pop_front());
            upd_rdfifo();
        end
        @(posedge clk); #1;
        chk({tag, ":idle"}, {27'd0, wb.ACK_I, wb.ERR_I, wb.RTY_I, rd_en, wr_en}, 32'd0);
        chk({tag, ":idledat"}, wb.DAT_I, 32'd0);
    endtask

    task automatic pulse_op_ack();
        @(negedge clk);
        op_ack = 1'b1;
        chk("opack:before", {31'd0, op_req}, {31'd0, m_opreq});
        @(posedge clk); #1;
        m_opreq = 1'b0;
        chk("opack:after", {31'd0, op_req}, {31'd0, m_opreq});
        @(negedge clk);
        op_ack = 1'b0;
    endtask

    initial begin
        wb.CYC_O = 1'b0; wb.STB_O = 1'b0; wb.WE_O = 1'b0; wb.ADR_O = '0; wb.DAT_O = '0;
        wb.SEL_O = 1'b1; wb.CTI_O = 3'b000; wb.LOCK_O = 1'b0; wb.TGA_O = '0; wb.TGC_O = '0;
        wb.TGD_O = 1'b0;
        model_reset();
        upd_rdfifo();
        #23;
        chk("reset:resp", {28'd0, wb.ACK_I, wb.ERR_I, wb.RTY_I, op_req}, 32'd0);
        chk("reset:regs", op_reg | start_reg | end_reg | wb.DAT_I, 32'd0);
        rst_n = 1'b1;

        // 1: status read, idle core, empty read FIFO, write FIFO has space
        bus_txn("status", 1'b0, 3'd0, 32'h0, 1'b1);

        // 2: program a transfer and hand it to the core
        bus_txn("wr_start", 1'b1, 3'd2, 32'h100, 1'b1);
        bus_txn("wr_end", 1'b1, 3'd3, 32'h107, 1'b1);
        bus_txn("wr_op", 1'b1, 3'd1, cOpRead, 1'b1);
        // 3: parameter writes are retried while the request is pending
        bus_txn("busy_wr", 1'b1, 3'd2, 32'hFFFF, 1'b1);
        bus_txn("status_busy", 1'b0, 3'd0, 32'h0, 1'b1);
        pulse_op_ack();
        pulse_op_ack();

        // 4: read FIFO drain in order, then retry on empty
        rdq.push_back(32'hDEADBEEF);
        rdq.push_back(32'hCAFEF00D);
        upd_rdfifo();
        bus_txn("rd0", 1'b0, 3'd4, 32'h0, 1'b1);
        bus_txn("rd1", 1'b0, 3'd4, 32'h0, 1'b1);
        bus_txn("rd_empty", 1'b0, 3'd4, 32'h0, 1'b1);

        // 5: write FIFO push, then retry when full
        wr_full = 1'b0;
        bus_txn("push", 1'b1, 3'd5, 32'h12345678, 1'b1);
        wr_full = 1'b1;
        bus_txn("push_full", 1'b1, 3'd5, 32'h9ABCDEF0, 1'b1);
        wr_full = 1'b0;
        bus_txn("push_nosel", 1'b1, 3'd5, 32'h55555555, 1'b0);
        bus_txn("wr_nosel", 1'b1, 3'd3, 32'h77777777, 1'b0);

        // 6: error terminations
        bus_txn("err_rd6", 1'b0, 3'd6, 32'h0, 1'b1);
        bus_txn("err_wr0", 1'b1, 3'd0, 32'h1234, 1'b1);
        bus_txn("err_rd5", 1'b0, 3'd5, 32'h0, 1'b1);
        bus_txn("err_wr7", 1'b1, 3'd7, 32'h1, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            logic       we, sel;
            logic [2:0] adr;
            ctrl_idle = ($urandom_range(0, 3) != 0);
            wr_full   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                rdq.push_back($urandom);
                upd_rdfifo();
            end
            if ($urandom_range(0, 3) == 0) pulse_op_ack();
            we  = 1'($urandom_range(0, 1));
            adr = 3'($urandom_range(0, 7));
            sel = ($urandom_range(0, 7) != 0);
            bus_txn("rand", we, adr, $urandom, sel);
        end

        // Reset while a response is on the bus
        ctrl_idle = 1'b1;
        wr_full   = 1'b0;
        if (m_opreq) pulse_op_ack();
        bus_txn("pre_start", 1'b1, 3'd2, 32'hA5A5A5A5, 1'b1);
        bus_txn("pre_op", 1'b1, 3'd1, cOpWrite, 1'b1);
        @(negedge clk);
        wb.CYC_O = 1'b1; wb.STB_O = 1'b1; wb.WE_O = 1'b0; wb.ADR_O = 3'd1; wb.SEL_O = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid:ack", {31'd0, wb.ACK_I}, 32'd1);
        chk("rst_mid:dat", wb.DAT_I, cOpWrite);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mid:resp", {27'd0, wb.ACK_I, wb.ERR_I, wb.RTY_I, op_req, rd_en}, 32'd0);
        chk("rst_mid:regs", {op_reg, start_reg}, {m_op, m_start});
        chk("rst_mid:end", end_reg | wb.DAT_I | wr_data, m_end);
        @(negedge clk);
        wb.CYC_O = 1'b0; wb.STB_O = 1'b0;
        rst_n = 1'b1;
        bus_txn("post_rst", 1'b0, 3'd2, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_wb_slave.md
Name: sd_wb_slave

Overview:
Wishbone B4 slave register front-end of the SD host controller; consumes the Wishbone master signals (CYC_O/STB_O/ADR_O/...) and drives the response side (ACK_I/ERR_I/RTY_I/DAT_I).
- Holds the operation, start-address and end-address registers.
- Hands new operations to the SD controller core through a req/ack handshake.
- Bridges the read-data and write-data FIFOs to the bus.
- Single clock domain shared with the controller core and FIFOs.

Parameters:
cWishboneWidth, 32, data width of DAT_O/DAT_I/FIFO data
cRegAddrWidth, 3, register address width (ADR_O[6:4])

Ports:
CLK_I  in  1  Wishbone/system clock
inResetAsync  in  1  asynchronous active-low reset
CYC_O  in  1  cycle valid
STB_O  in  1  strobe
WE_O  in  1  1=write, 0=read
ADR_O  in  3  register select, bits [6:4]
DAT_O  in  32  write data from master
SEL_O  in  1  byte-lane select (one 32-bit lane)
CTI_O  in  3  aCTI cycle type (accepted, treated as classic)
LOCK_O, TGA_O, TGC_O, TGD_O  in  1/32/32/1  ignored
ACK_I  out  1  normal termination
ERR_I  out  1  error termination
RTY_I  out  1  retry termination
DAT_I  out  32  read data to master
oOpReq  out  1  new operation pending for controller
iOpAck  in  1  controller has accepted the operation
iCtrlIdle  in  1  controller idle
oOperation  out  32  operation register
oStartAddr  out  32  start block address
oEndAddr  out  32  end block address
iRdFifoData  in  32  read FIFO head (show-ahead)
iRdFifoEmpty  in  1  read FIFO empty
oRdFifoRdEn  out  1  read FIFO pop
oWrFifoData  out  32  write FIFO data
oWrFifoWrEn  out  1  write FIFO push
iWrFifoFull  in  1  write FIFO full

Behaviour:
Reset (inResetAsync=0, asynchronous): all outputs 0, state Idle.

Register map (ADR_O):
- 0: Status, RO. bit0=iCtrlIdle&!oOpReq; bit1=!iRdFifoEmpty; bit2=!iWrFifoFull; others 0.
- 1: Operation, RW. cOpRead=32'h10, cOpWrite=32'h01.
- 2: StartAddr, RW.
- 3: EndAddr, RW.
- 4: ReadData, RO; each read pops the read FIFO.
- 5: WriteData, WO; each write pushes the write FIFO.
- 6, 7: unmapped.

Bus FSM, states Idle and Respond:
- Idle: a request is sampled when CYC_O&STB_O. Next state Respond. ACK_I, ERR_I or RTY_I (exactly one) asserts in the next cycle, for exactly one cycle.
- Respond: all terminations drop; back to Idle. Max one transfer per 2 cycles; CTI bursts are serviced as consecutive classic cycles.
- CYC_O deasserted while in Respond: response is still emitted for one cycle, then Idle; no further side effects.

Termination rules, decided at the sampling edge:
- ERR_I: unmapped ADR; write to 0 or 4; read of 5.
- RTY_I: read of 4 while iRdFifoEmpty; write of 5 while iWrFifoFull; write to 1/2/3 while oOpReq=1 or iCtrlIdle=0 (busy).
- ACK_I: all other cases.
- A RTY or ERR termination causes no register update, FIFO push or FIFO pop.

Read data and write strobes:
- DAT_I: registered at the sampling edge and valid with ACK_I; DAT_I=0 with ERR_I/RTY_I and in Idle.
- SEL_O=0 on an ACKed write: termination is ACK, no register or FIFO update.

FIFO timing:
- Read pop: oRdFifoRdEn pulses 1 cycle in the Respond cycle; DAT_I holds the already-registered head word.
- Write push: oWrFifoData<=DAT_O and oWrFifoWrEn pulses 1 cycle in the Respond cycle.

Operation handshake:
- ACKed write to reg 1 sets oOpReq=1 in the Respond cycle.
- oOpReq clears in the cycle after iOpAck=1 is sampled.
- iOpAck while oOpReq=0 is ignored.
- oOperation/oStartAddr/oEndAddr are stable while oOpReq=1 (busy writes get RTY).

Reset mid-transfer: outputs clear immediately; a pending request is lost.

Decomposition:
- Shared package sd_wb_pkg: cWishboneWidth, aCTI enum (classic 000, const 001, incr 010, end 111), register address constants cRegStatus..cRegWriteData, cOpRead, cOpWrite, status bit indices.
- Single module; no sub-module (FIFOs are external).

Test Plan:
1. Reset, read ADR 0 with iCtrlIdle=1, read FIFO empty, write FIFO not full -> ACK_I one cycle after STB, DAT_I=32'h5, all other outputs 0.
2. Write ADR 2=32'h100, ADR 3=32'h107, ADR 1=32'h10 -> each ACKed; oStartAddr=32'h100, oEndAddr=32'h107, oOperation=32'h10, oOpReq=1. Pulse iOpAck -> oOpReq=0 next cycle.
3. With oOpReq=1, write ADR 2=32'hFFFF -> RTY_I, oStartAddr stays 32'h100.
4. Read FIFO holding 32'hDEADBEEF then 32'hCAFEF00D, two reads of ADR 4 -> DAT_I values in that order, one oRdFifoRdEn pulse each. Third read with empty FIFO -> RTY_I, no pop.
5. iWrFifoFull=0, write ADR 5=32'h12345678 -> oWrFifoWrEn pulse, oWrFifoData=32'h12345678. iWrFifoFull=1, repeat -> RTY_I, no push.
6. Read ADR 6, write ADR 0, read ADR 5 -> ERR_I each, DAT_I=0. Assert inResetAsync=0 during Respond -> ACK_I drops asynchronously, all registers 0.
